// File: rtl/serdes_decrypt_rx.sv
// serdes_decrypt_rx: serial receive path of the secure SERDES link.
// A start pulse latches the per-frame key, then WIDTH cipher bits arrive MSB
// first; each is XORed with the matching key bit and shifted into the
// plaintext register, and the completed byte is presented with a one-cycle
// data_valid strobe. A start arriving mid-frame aborts the frame and flags
// frame_err.
// Optional build macro: SERDES_RX_PARITY_EN adds a trailing unencrypted even
// parity bit (PARITY state) and the parity_err output.
module serdes_decrypt_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             cipher_bit,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err
`ifdef SERDES_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERDES_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;
    logic             busy_q;
    logic             frame_err_q;
`ifdef SERDES_RX_PARITY_EN
    logic             parity_err_q;
`endif

    logic [CW-1:0]    bit_idx_d;
    logic             plain_bit_d;
    logic [WIDTH-1:0] shift_d;
    logic             abort_d;

    // Decrypt the incoming bit against the key bit for this position and
    // decide whether a start in SHIFT aborts the current frame.
    always_comb begin
        bit_idx_d   = LAST - cnt_q;
        plain_bit_d = cipher_bit ^ key_q[bit_idx_d];
        shift_d     = {shift_q[WIDTH-2:0], plain_bit_d};
`ifdef SERDES_RX_PARITY_EN
        // Every data-bit edge aborts; only the parity edge chains frames.
        abort_d     = start;
`else
        // A start on the last data bit chains the next frame instead.
        abort_d     = start && (cnt_q != LAST);
`endif
    end

    // Frame FSM with registered outputs; pulses are cleared every enabled
    // cycle and also while ena is low so they never stretch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            key_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else if (!ena) begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // The cipher bit on the start edge carries no data.
                    if (start) begin
                        key_q   <= key_in;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort_d) begin
                        // Restart with the new key; data_out keeps the old byte.
                        frame_err_q <= 1'b1;
                        key_q       <= key_in;
                        cnt_q       <= '0;
                    end else begin
                        shift_q <= shift_d;
                        if (cnt_q == LAST) begin
`ifdef SERDES_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            data_out_q   <= shift_d;
                            data_valid_q <= 1'b1;
                            if (start) begin
                                key_q <= key_in;
                                cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
`ifdef SERDES_RX_PARITY_EN
                PARITY: begin
                    // Parity bit is sent in clear: even parity over plaintext.
                    data_out_q   <= shift_q;
                    data_valid_q <= 1'b1;
                    parity_err_q <= cipher_bit ^ (^shift_q);
                    if (start) begin
                        key_q   <= key_in;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
`ifdef SERDES_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serdes_decrypt_rx.sv
// Directed bench for serdes_decrypt_rx with a scoreboard of expected bytes.
// Expected plaintexts are pushed when a frame is driven and popped whenever
// the DUT strobes data_valid. Build with SERDES_RX_PARITY_EN defined to
// exercise the parity variant.
module tb_serdes_decrypt_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start;
    logic       cipher_bit;
    logic [7:0] key_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
`ifdef SERDES_RX_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ferr_cnt = 0;
    int   valid_cnt = 0;

    serdes_decrypt_rx #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .cipher_bit (cipher_bit),
        .key_in     (key_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err)
`ifdef SERDES_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample outputs 1 ns after the edge and feed
    // any valid strobe to the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (frame_err === 1'b1) ferr_cnt++;
        if (data_valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(data_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
`ifdef SERDES_RX_PARITY_EN
                check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
            end
        end
    endtask

    task automatic push_exp(input logic [7:0] key, input logic [7:0] c, input logic bad_par);
        exp_t e;
        e.data = key ^ c;
        e.perr = bad_par;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] key);
        start  = 1'b1;
        key_in = key;
        step();
        start  = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] c, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            cipher_bit = c[i];
            step();
        end
    endtask

    // Last data bit (plus parity bit when built in); optionally chains a
    // new start on the final edge. Checks the valid strobe lands right there.
    task automatic finish_last(input logic [7:0] key, input logic [7:0] c, input logic bad_par,
                               input logic nxt_start, input logic [7:0] nxt_key);
        cipher_bit = c[0];
`ifdef SERDES_RX_PARITY_EN
        step();
        check("no_valid_before_parity", 32'(data_valid), 32'd0);
        cipher_bit = (^(key ^ c)) ^ bad_par;
`endif
        start  = nxt_start;
        key_in = nxt_key;
        step();
        start  = 1'b0;
        check("valid_latency", 32'(data_valid), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] key, input logic [7:0] c, input logic bad_par);
        push_exp(key, c, bad_par);
        do_start(key);
        send_range(c, 7, 1);
        check("busy_mid_frame", 32'(busy), 32'd1);
        finish_last(key, c, bad_par, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; cipher_bit = 1'b0; key_in = 8'h00;
        #12;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        #10 rst = 1'b0;
        step();

        // Basic frame: key 0x99, cipher 0xA5 -> 0x3C
        push_exp(8'h99, 8'hA5, 1'b0);
        do_start(8'h99);
        check("basic_busy_T1", 32'(busy), 32'd1);
        send_range(8'hA5, 7, 1);
        check("basic_busy_T8", 32'(busy), 32'd1);
        check("basic_no_early_valid", 32'(data_valid), 32'd0);
        finish_last(8'h99, 8'hA5, 1'b0, 1'b0, 8'h00);
        check("basic_frame_err", 32'(frame_err), 32'd0);
        check("basic_busy_done", 32'(busy), 32'd0);
        step();
        check("basic_valid_one_cycle", 32'(data_valid), 32'd0);
        check("basic_data_hold", 32'(data_out), 32'h3C);

        // Zero key and all-ones key
        run_frame(8'h00, 8'hFF, 1'b0);
        step();
        run_frame(8'hFF, 8'hFF, 1'b0);
        step();

        // Abort: 3 bits then a new start with key 0x0F, cipher 0xF0 -> 0xFF
        do_start(8'h55);
        send_range(8'hC3, 7, 5);
        push_exp(8'h0F, 8'hF0, 1'b0);
        do_start(8'h0F);
        check("abort_frame_err", 32'(frame_err), 32'd1);
        check("abort_data_hold", 32'(data_out), 32'h00);
        check("abort_busy", 32'(busy), 32'd1);
        send_range(8'hF0, 7, 1);
        finish_last(8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00);
        check("abort_ferr_count", 32'(ferr_cnt), 32'd1);
        step();

        // Back-to-back: frame 2 starts on the final edge of frame 1
        push_exp(8'h00, 8'h12, 1'b0);
        push_exp(8'h00, 8'h34, 1'b0);
        do_start(8'h00);
        send_range(8'h12, 7, 1);
        finish_last(8'h00, 8'h12, 1'b0, 1'b1, 8'h00);
        check("b2b_busy", 32'(busy), 32'd1);
        send_range(8'h34, 7, 1);
        check("b2b_no_early_valid", 32'(data_valid), 32'd0);
        finish_last(8'h00, 8'h34, 1'b0, 1'b0, 8'h00);
        check("b2b_ferr_count", 32'(ferr_cnt), 32'd1);
        step();

        // ena low 3 cycles mid-frame with garbage on the line
        push_exp(8'hA0, 8'h5A, 1'b0);
        do_start(8'hA0);
        send_range(8'h5A, 7, 4);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cipher_bit = ~cipher_bit;
            start = (i == 1);
            step();
            check("ena_low_valid", 32'(data_valid), 32'd0);
            check("ena_low_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        ena = 1'b1;
        send_range(8'h5A, 3, 1);
        check("ena_no_early_valid", 32'(data_valid), 32'd0);
        finish_last(8'hA0, 8'h5A, 1'b0, 1'b0, 8'h00);
        check("ena_ferr_count", 32'(ferr_cnt), 32'd1);
        step();

        // Reset mid-frame discards the partial frame
        do_start(8'h33);
        send_range(8'hEE, 7, 4);
        #2 rst = 1'b1;
        #1;
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(data_valid), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("postrst_data_out", 32'(data_out), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);
        run_frame(8'h0F, 8'h3C, 1'b0);
        check("postrst_decode", 32'(data_out), 32'h33);
        step();

`ifdef SERDES_RX_PARITY_EN
        // Parity: correct bit, then a flipped bit
        run_frame(8'h99, 8'hA5, 1'b0);
        check("par_ok_data", 32'(data_out), 32'h3C);
        check("par_ok_flag", 32'(parity_err), 32'd0);
        step();
        run_frame(8'h99, 8'hA5, 1'b1);
        check("par_bad_data", 32'(data_out), 32'h3C);
        check("par_bad_flag", 32'(parity_err), 32'd1);
        step();
        check("par_flag_one_cycle", 32'(parity_err), 32'd0);
`endif

        for (int i = 0; i < 4; i++) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("ferr_total", 32'(ferr_cnt), 32'd1);
`ifdef SERDES_RX_PARITY_EN
        check("valid_total", 32'(valid_cnt), 32'd10);
`else
        check("valid_total", 32'(valid_cnt), 32'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_decrypt_rx.md
Name: serdes_decrypt_rx

Overview:
- Receive-side counterpart of the secure SERDES encrypt path.
- Accepts a one-cycle start pulse followed by one cipher bit per clock, MSB first.
- XOR-decrypts each bit against a per-frame key byte latched at start, assembles the plaintext byte, and presents it with a one-cycle valid strobe.
- Sits between the serial pad inputs and the parallel consumer logic of the TinyTapeout user project.

Parameters:
- WIDTH, 8, bits per frame (payload and key width).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ena  input  1  clock enable; when low, all state holds.
- start  input  1  frame start pulse; sampled only while ena=1.
- cipher_bit  input  1  serial cipher bit, MSB first.
- key_in  input  WIDTH  decryption key; latched on accepted start.
- data_out  output  WIDTH  decrypted byte; holds until the next frame completes.
- data_valid  output  1  one-cycle pulse on frame completion.
- busy  output  1  high while in SHIFT (or PARITY).
- frame_err  output  1  one-cycle pulse when a frame is aborted by a premature start.

Behaviour:
- Reset (async, rst=1): state=IDLE, bit counter=0, shift reg=0, key reg=0, data_out=0, data_valid=0, busy=0, frame_err=0 (parity_err=0 when enabled). Reset mid-frame discards the partial frame; no valid and no error pulse.
- ena=0: no state change. data_valid and frame_err are forced low that cycle, so a pulse never stretches.
- States: IDLE, SHIFT, plus PARITY when the feature is compiled in.
- IDLE:
  - start=1 at edge T → latch key_in, clear counter, go to SHIFT.
  - cipher_bit at edge T is ignored.
- SHIFT:
  - Edges T+1..T+WIDTH each sample one bit into the shift reg, MSB first. Plain bit = cipher_bit XOR key[WIDTH-1-idx], idx = 0..WIDTH-1.
  - At edge T+WIDTH (last bit): data_out loads the full plaintext and data_valid=1 during the following cycle only; next state is IDLE (or PARITY).
  - Latency: data_valid high in cycle T+WIDTH+1, relative to the start edge T.
- start=1 in SHIFT before the last bit:
  - Abort the frame; frame_err=1 for one cycle.
  - Relatch key_in, clear the counter, stay in SHIFT. That edge counts as the new T.
  - data_out unchanged; no data_valid.
- start=1 on the last-bit edge: the current frame completes normally (data_valid pulses) and the start is accepted as a new frame start; next state SHIFT. Back-to-back frames carry no gap cycle.
- Counter never wraps past WIDTH-1; width is clog2(WIDTH).
- busy = (state != IDLE), registered.

Optional Feature:
- Macro SERDES_RX_PARITY_EN.
- Defined:
  - Adds output parity_err (1 bit) and state PARITY.
  - After the last data bit, one extra cipher bit is sampled unencrypted as even parity over the plaintext.
  - data_out and data_valid update on the parity edge, at T+WIDTH+1, so valid is high in cycle T+WIDTH+2.
  - parity_err pulses with data_valid on mismatch; data_out is still updated.
  - start on the parity edge is accepted back-to-back; start on a data-bit edge aborts as above.
- Undefined: no parity_err port and no PARITY state; timing as in Behaviour.

Test Plan:
- Basic frame: rst 20 ns; key_in=0x99; start pulse; cipher bits 0xA5 MSB first → data_valid one cycle at T+9, data_out=0x3C, frame_err=0, busy high T+1..T+8.
- Zero key: key_in=0x00, cipher 0xFF → data_out=0xFF; then key_in=0xFF, cipher 0xFF → data_out=0x00.
- Abort: start; 3 bits; start again with key_in=0x0F; 8 bits of 0xF0 → frame_err pulse at the 2nd start, a single data_valid, data_out=0xFF.
- Back-to-back: start asserted on the last-bit edge of frame 1 (cipher 0x12, key 0x00), then frame 2 (cipher 0x34) → two valid pulses 8 cycles apart, data_out 0x12 then 0x34, no frame_err.
- ena/reset: ena low 3 cycles mid-frame → result still correct, valid delayed 3 cycles; rst asserted mid-frame → all outputs 0, no pulses, next frame decodes correctly.
- SERDES_RX_PARITY_EN: cipher 0xA5, key 0x99, parity bit 0 → valid at T+10, data_out=0x3C, parity_err=0; parity bit 1 → parity_err=1.
